// File: rtl/md_unit_ctrl_if.sv
// Pipeline-side bundle for the multiply/divide sequencer: instruction and operand inputs, and HI/LO, md_out and stall outputs.
interface md_unit_ctrl_if;
  logic [31:0] IDEX_IR;
  logic [31:0] IFID_IR;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        ex_cancel;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  modport master (
    output IDEX_IR, IFID_IR, rs_val, rt_val, ex_cancel,
    input  md_out, hi, lo, busy, stall
  );

  modport slave (
    input  IDEX_IR, IFID_IR, rs_val, rt_val, ex_cancel,
    output md_out, hi, lo, busy, stall
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer beside EX: owns HI/LO, serves mfhi/mflo/mthi/mtlo and stalls IF/ID while an op runs.
// Define MD_MADD_EN to add madd/maddu/msub/msubu, which accumulate into {HI,LO} at commit.
//
// state     | meaning
// S_IDLE    | no op in flight; accepts md ops and HI/LO moves from ID/EX
// S_RUN_MUL | multiply (or multiply-accumulate) counting down to commit
// S_RUN_DIV | divide counting down to commit
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset_n,
  md_unit_ctrl_if.slave md
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN_MUL = 2'd1,
    S_RUN_DIV = 2'd2
  } state_t;

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  function automatic logic is_mul(input logic [31:0] ir);
    return (ir[31:26] == 6'b000000) && ((ir[5:0] == FN_MULT) || (ir[5:0] == FN_MULTU));
  endfunction

  function automatic logic is_div(input logic [31:0] ir);
    return (ir[31:26] == 6'b000000) && ((ir[5:0] == FN_DIV) || (ir[5:0] == FN_DIVU));
  endfunction

  function automatic logic is_move(input logic [31:0] ir);
    return (ir[31:26] == 6'b000000) &&
           ((ir[5:0] == FN_MFHI) || (ir[5:0] == FN_MTHI) ||
            (ir[5:0] == FN_MFLO) || (ir[5:0] == FN_MTLO));
  endfunction

  function automatic logic is_madd(input logic [31:0] ir);
`ifdef MD_MADD_EN
    return (ir[31:26] == 6'b011111) &&
           ((ir[5:0] == 6'b000000) || (ir[5:0] == 6'b000001) ||
            (ir[5:0] == 6'b000100) || (ir[5:0] == 6'b000101));
`else
    return 1'b0 & ir[0];
`endif
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       res_q, res_d;
  logic              dz_q, dz_d;
  logic              acc_q, acc_d;
  logic              sub_q, sub_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic [5:0]  idex_fn;
  logic        idex_mul, idex_div, idex_madd, idex_arith;
  logic        idex_mthi, idex_mtlo, idex_mfhi, idex_mflo;
  logic        ifid_md;
  logic        unused_ir_bits;

  assign idex_fn    = md.IDEX_IR[5:0];
  assign idex_mul   = is_mul(md.IDEX_IR);
  assign idex_div   = is_div(md.IDEX_IR);
  assign idex_madd  = is_madd(md.IDEX_IR);
  assign idex_arith = idex_mul | idex_div | idex_madd;
  assign idex_mthi  = (md.IDEX_IR[31:26] == 6'b000000) && (idex_fn == FN_MTHI);
  assign idex_mtlo  = (md.IDEX_IR[31:26] == 6'b000000) && (idex_fn == FN_MTLO);
  assign idex_mfhi  = (md.IDEX_IR[31:26] == 6'b000000) && (idex_fn == FN_MFHI);
  assign idex_mflo  = (md.IDEX_IR[31:26] == 6'b000000) && (idex_fn == FN_MFLO);
  assign ifid_md    = is_mul(md.IFID_IR) | is_div(md.IFID_IR) |
                      is_move(md.IFID_IR) | is_madd(md.IFID_IR);
  assign unused_ir_bits = ^{md.IDEX_IR[25:6], md.IFID_IR[25:6]};

  // funct bit 0 selects unsigned for every arith op in both encodings.
  logic        op_signed;
  logic [63:0] mul_a, mul_b, prod;
  assign op_signed = ~idex_fn[0];
  assign mul_a = {{32{op_signed & md.rs_val[31]}}, md.rs_val};
  assign mul_b = {{32{op_signed & md.rt_val[31]}}, md.rt_val};
  assign prod  = mul_a * mul_b;

  // Signed divide goes through magnitudes so the most-negative / -1 case wraps cleanly.
  logic        neg_a, neg_b, div_zero;
  logic [31:0] mag_a, mag_b, divisor, uquo, urem, quo, rem;
  assign neg_a    = op_signed & md.rs_val[31];
  assign neg_b    = op_signed & md.rt_val[31];
  assign mag_a    = neg_a ? (32'd0 - md.rs_val) : md.rs_val;
  assign mag_b    = neg_b ? (32'd0 - md.rt_val) : md.rt_val;
  assign div_zero = (md.rt_val == 32'd0);
  assign divisor  = div_zero ? 32'd1 : mag_b;
  assign uquo     = mag_a / divisor;
  assign urem     = mag_a % divisor;
  assign quo      = (neg_a ^ neg_b) ? (32'd0 - uquo) : uquo;
  assign rem      = neg_a ? (32'd0 - urem) : urem;

  logic [63:0] hilo_acc;
  assign hilo_acc = sub_q ? ({hi_q, lo_q} - res_q) : ({hi_q, lo_q} + res_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      acc_q   <= acc_d;
      sub_q   <= sub_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dz_d    = dz_q;
    acc_d   = acc_q;
    sub_d   = sub_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (!md.ex_cancel) begin
          if (idex_mul || idex_madd) begin
            state_d = S_RUN_MUL;
            cnt_d   = MUL_LOAD;
            res_d   = prod;
            dz_d    = 1'b0;
            acc_d   = idex_madd;
            sub_d   = idex_madd & idex_fn[2];
          end else if (idex_div) begin
            state_d = S_RUN_DIV;
            cnt_d   = DIV_LOAD;
            res_d   = {rem, quo};
            dz_d    = div_zero;
            acc_d   = 1'b0;
            sub_d   = 1'b0;
          end else if (idex_mthi) begin
            hi_d = md.rs_val;
          end else if (idex_mtlo) begin
            lo_d = md.rs_val;
          end
        end
      end
      S_RUN_MUL: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (acc_q) begin
            hi_d = hilo_acc[63:32];
            lo_d = hilo_acc[31:0];
          end else begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RUN_DIV: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (!dz_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign md.busy   = (state_q != S_IDLE);
  assign md.hi     = hi_q;
  assign md.lo     = lo_q;
  assign md.md_out = idex_mfhi ? hi_q : (idex_mflo ? lo_q : 32'd0);
  assign md.stall  = ifid_md & (md.busy | idex_arith);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: mult/div latency, stall, HI/LO moves, divide-by-zero, cancel, reset abort, madd.
module tb_md_unit_ctrl;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  md_unit_ctrl_if bus ();

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] MULT  = 32'h0000_0018;
  localparam logic [31:0] DIV   = 32'h0000_001A;
  localparam logic [31:0] DIVU  = 32'h0000_001B;
  localparam logic [31:0] MFHI  = 32'h0000_0010;
  localparam logic [31:0] MTHI  = 32'h0000_0011;
  localparam logic [31:0] MFLO  = 32'h0000_0012;
  localparam logic [31:0] MTLO  = 32'h0000_0013;
  localparam logic [31:0] MADD  = 32'h7C00_0000;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] rs, input logic [31:0] rt);
    bus.IDEX_IR = ir;
    bus.rs_val  = rs;
    bus.rt_val  = rt;
  endtask

  task automatic test_reset;
    reset_n       = 1'b0;
    bus.IDEX_IR   = NOP;
    bus.IFID_IR   = NOP;
    bus.rs_val    = '0;
    bus.rt_val    = '0;
    bus.ex_cancel = 1'b0;
    #12;
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.md_out !== 32'd0) begin errors++; $display("FAIL reset_md_out got=%h exp=0", bus.md_out); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_mult;
    issue(MULT, 32'd3, 32'hFFFF_FFFE);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_pre_busy got=%b exp=0", bus.busy); end
    tick();
    issue(NOP, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mult_busy[%0d] got=%b exp=1", i, bus.busy); end
      checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL mult_lo_early[%0d] got=%h exp=0", i, bus.lo); end
      tick();
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_end got=%b exp=0", bus.busy); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", bus.lo); end
  endtask

  task automatic test_div_stall;
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    bus.IFID_IR = MFLO;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL div_stall_issue got=%b exp=1", bus.stall); end
    tick();
    issue(NOP, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL div_busy[%0d] got=%b exp=1", i, bus.busy); end
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL div_stall[%0d] got=%b exp=1", i, bus.stall); end
      tick();
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL div_busy_end got=%b exp=0", bus.busy); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL div_stall_end got=%b exp=0", bus.stall); end
    bus.IDEX_IR = MFLO;
    bus.IFID_IR = NOP;
    #1;
    checks++; if (bus.md_out !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_mflo got=%h exp=fffffffd", bus.md_out); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", bus.hi); end
    tick();
    issue(NOP, 32'd0, 32'd0);
  endtask

  task automatic test_move;
    issue(MTHI, 32'h0000_1234, 32'd0);
    bus.IFID_IR = MFHI;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL move_stall got=%b exp=0", bus.stall); end
    tick();
    issue(MFHI, 32'd0, 32'd0);
    bus.IFID_IR = NOP;
    #1;
    checks++; if (bus.md_out !== 32'h0000_1234) begin errors++; $display("FAIL move_mfhi got=%h exp=00001234", bus.md_out); end
    tick();
    issue(NOP, 32'd0, 32'd0);
    #1;
    checks++; if (bus.md_out !== 32'd0) begin errors++; $display("FAIL move_md_out_idle got=%h exp=0", bus.md_out); end
  endtask

  task automatic test_div_zero;
    issue(MTHI, 32'h0000_00AA, 32'd0);
    tick();
    issue(MTLO, 32'h0000_00AA, 32'd0);
    tick();
    issue(DIVU, 32'd5, 32'd0);
    tick();
    issue(NOP, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL dz_busy[%0d] got=%b exp=1", i, bus.busy); end
      tick();
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dz_busy_end got=%b exp=0", bus.busy); end
    checks++; if (bus.hi !== 32'h0000_00AA) begin errors++; $display("FAIL dz_hi got=%h exp=000000aa", bus.hi); end
    checks++; if (bus.lo !== 32'h0000_00AA) begin errors++; $display("FAIL dz_lo got=%h exp=000000aa", bus.lo); end
  endtask

  task automatic test_cancel;
    issue(MULT, 32'd2, 32'd3);
    bus.ex_cancel = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got=%b exp=0", bus.busy); end
    issue(MTHI, 32'h0000_0055, 32'd0);
    tick();
    checks++; if (bus.hi !== 32'h0000_00AA) begin errors++; $display("FAIL cancel_hi got=%h exp=000000aa", bus.hi); end
    checks++; if (bus.lo !== 32'h0000_00AA) begin errors++; $display("FAIL cancel_lo got=%h exp=000000aa", bus.lo); end
    bus.ex_cancel = 1'b0;
    issue(MULT, 32'd7, 32'hFFFF_FFFA);
    tick();
    issue(NOP, 32'd0, 32'd0);
    bus.ex_cancel = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL run_cancel_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.lo !== 32'hFFFF_FFD6) begin errors++; $display("FAIL run_cancel_lo got=%h exp=ffffffd6", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL run_cancel_hi got=%h exp=ffffffff", bus.hi); end
    bus.ex_cancel = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    issue(DIV, 32'd100, 32'd7);
    tick();
    issue(NOP, 32'd0, 32'd0);
    tick();
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got=%b exp=1", bus.busy); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL abort_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL abort_lo got=%h exp=0", bus.lo); end
    #3;
    reset_n = 1'b1;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_div_overflow;
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    issue(NOP, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got=%h exp=80000000", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL ovf_hi got=%h exp=0", bus.hi); end
    issue(DIV, 32'd7, 32'hFFFF_FFFE);
    tick();
    issue(NOP, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_lo got=%h exp=fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL sdiv_hi got=%h exp=1", bus.hi); end
  endtask

  task automatic test_back_to_back;
    issue(MULT, 32'd3, 32'd5);
    tick();
    issue(DIV, 32'd9, 32'd3);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_mul_busy[%0d] got=%b exp=1", i, bus.busy); end
      if (i == 4) issue(NOP, 32'd0, 32'd0);
      tick();
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_mul_end got=%b exp=0", bus.busy); end
    checks++; if (bus.lo !== 32'd15) begin errors++; $display("FAIL b2b_mul_lo got=%h exp=0000000f", bus.lo); end
    issue(DIVU, 32'hFFFF_FFF0, 32'd3);
    tick();
    issue(NOP, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_div_end got=%b exp=0", bus.busy); end
    checks++; if (bus.lo !== 32'h5555_5550) begin errors++; $display("FAIL b2b_divu_lo got=%h exp=55555550", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL b2b_divu_hi got=%h exp=0", bus.hi); end
  endtask

  task automatic test_madd;
    issue(MTHI, 32'd0, 32'd0);
    tick();
    issue(MTLO, 32'd1, 32'd0);
    tick();
    issue(MADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.IFID_IR = MADD;
    #1;
`ifdef MD_MADD_EN
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL madd_stall got=%b exp=1", bus.stall); end
    tick();
    issue(NOP, 32'd0, 32'd0);
    bus.IFID_IR = NOP;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL madd_busy[%0d] got=%b exp=1", i, bus.busy); end
      tick();
    end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL madd_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'd2) begin errors++; $display("FAIL madd_lo got=%h exp=2", bus.lo); end
`else
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL madd_off_stall got=%b exp=0", bus.stall); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL madd_off_busy got=%b exp=0", bus.busy); end
    issue(NOP, 32'd0, 32'd0);
    bus.IFID_IR = NOP;
    checks++; if (bus.lo !== 32'd1) begin errors++; $display("FAIL madd_off_lo got=%h exp=1", bus.lo); end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_mult();
    test_div_stall();
    test_move();
    test_div_zero();
    test_cancel();
    test_reset_mid_op();
    test_div_overflow();
    test_back_to_back();
    test_madd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
